// File: rtl/shift_seq_ctrl.sv
// ----------------------------------------------------------------------------
// shift_seq_ctrl
//
// Sequencer that loads a word into an external serial-in/parallel-out shift
// register and reads it back. The register runs on the same clock as this
// block.
//
// A transaction runs in four steps:
//   1. Accept din on a start strobe.
//   2. Clear the register.
//   3. Shift the word in MSB-first, WIDTH cycles.
//   4. Capture the parallel output into dout and compare it with the word
//      that was sent.
//
// Optional build macro:
//   SHIFT_SEQ_CHECK_EN  defined   -> err reports a readback mismatch
//                       undefined -> comparator not built, err tied 0
//   The port list is the same in both builds.
//
// Parameters:
//   WIDTH    word width and shift count (minimum 2)
//
// Ports:
//   ck       clock; all state changes on rising edge
//   res      asynchronous active-low reset
//   start    request, sampled only in IDLE
//   din      word to load, sampled on the edge that accepts start
//   busy     high in CLR, SHIFT and CHECK
//   sft_clr  synchronous clear to the shift register
//   sft_en   shift enable to the shift register
//   sft_d    serial data to the shift register
//   sft_q    shift register parallel output
//   dout     value captured from sft_q at CHECK
//   done     one-cycle completion pulse
//   err      readback mismatch flag
// ----------------------------------------------------------------------------
module shift_seq_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             ck,
    input  logic             res,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             sft_clr,
    output logic             sft_en,
    output logic             sft_d,
    input  logic [WIDTH-1:0] sft_q,
    output logic [WIDTH-1:0] dout,
    output logic             done,
    output logic             err
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StClr,
        StShift,
        StCheck
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             done_q, done_d;

    // The bit for the current shift cycle always sits in the MSB of the
    // shifted shadow.
    logic [WIDTH-1:0] shadow_shl;
    assign shadow_shl = shadow_q << cnt_q;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        dout_d   = dout_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shadow_d = din;
                    cnt_d    = '0;
                    state_d  = StClr;
                end
            end
            StClr: begin
                state_d = StShift;
            end
            StShift: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StCheck: begin
                dout_d  = sft_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            shadow_q <= '0;
            dout_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Moore outputs, decoded only from registered state. Because of this, an
    // asynchronous reset drops the strobes at once.
    // ------------------------------------------------------------------------
    always_comb begin
        busy    = 1'b0;
        sft_clr = 1'b0;
        sft_en  = 1'b0;
        sft_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
            end
            StClr: begin
                busy    = 1'b1;
                sft_clr = 1'b1;
            end
            StShift: begin
                busy   = 1'b1;
                sft_en = 1'b1;
                sft_d  = shadow_shl[WIDTH-1];
            end
            StCheck: begin
                busy = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign dout = dout_q;
    assign done = done_q;

    // ------------------------------------------------------------------------
    // Readback comparator. err holds until the next CHECK capture.
    // ------------------------------------------------------------------------
`ifdef SHIFT_SEQ_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == StCheck) begin
            err_d = (sft_q != shadow_q);
        end
    end

    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;

    localparam int unsigned W = 4;

`ifdef SHIFT_SEQ_CHECK_EN
    localparam bit CheckEn = 1'b1;
`else
    localparam bit CheckEn = 1'b0;
`endif

    logic         ck = 1'b0;
    logic         res = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] din = '0;
    logic         busy, sft_clr, sft_en, sft_d, done, err;
    logic [W-1:0] sft_q, dout;

    // Behavioural shift register with an optional stuck-at-0 output mask.
    logic [W-1:0] q_m = '0;
    logic [W-1:0] stuck_mask = '0;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard of expected results, one entry per accepted transaction.
    logic [W-1:0] exp_dout_q[$];
    logic         exp_err_q[$];
    logic         last_err = 1'b0;

    shift_seq_ctrl #(.WIDTH(W)) dut (
        .ck      (ck),
        .res     (res),
        .start   (start),
        .din     (din),
        .busy    (busy),
        .sft_clr (sft_clr),
        .sft_en  (sft_en),
        .sft_d   (sft_d),
        .sft_q   (sft_q),
        .dout    (dout),
        .done    (done),
        .err     (err)
    );

    always #5 ck = ~ck;

    always @(posedge ck) begin
        if (sft_clr)     q_m <= '0;
        else if (sft_en) q_m <= {q_m[W-2:0], sft_d};
    end

    assign sft_q = q_m & ~stuck_mask;

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic push_exp(input logic [W-1:0] w);
        logic [W-1:0] got;
        got = w & ~stuck_mask;
        exp_dout_q.push_back(got);
        exp_err_q.push_back(CheckEn ? (got != w) : 1'b0);
    endtask

    // Waits (bounded) for done, then scores dout/err against the scoreboard.
    task automatic wait_done(input int max_cyc, input string tag);
        int k;
        logic [W-1:0] e_d;
        logic         e_e;
        k = 0;
        while (!done && k < max_cyc) begin
            step();
            k++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_timeout: done=%b required 1", tag, done);
            if (exp_dout_q.size() > 0) begin
                void'(exp_dout_q.pop_front());
                void'(exp_err_q.pop_front());
            end
        end else if (exp_dout_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s unexpected_done: queue empty", tag);
        end else begin
            e_d = exp_dout_q.pop_front();
            e_e = exp_err_q.pop_front();
            last_err = e_e;
            n_checks++;
            if ({dout, err} !== {e_d, e_e}) begin
                n_fail++;
                $display("FAIL %s result: dout=%b err=%b required dout=%b err=%b",
                         tag, dout, err, e_d, e_e);
            end
        end
    endtask

    task automatic test_reset();
        res = 1'b0;
        start = 1'b0;
        #3;
        n_checks++;
        if ({busy, sft_clr, sft_en, sft_d, done, err, dout} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: outs=%b required 0",
                     {busy, sft_clr, sft_en, sft_d, done, err, dout});
        end
        step();
        step();
        #2 res = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if ({busy, sft_clr, sft_en, sft_d, done, err, dout} !== '0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: outs=%b required 0", i,
                         {busy, sft_clr, sft_en, sft_d, done, err, dout});
            end
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] w;
        w = 4'b1010;
        din = w;
        start = 1'b1;
        push_exp(w);
        step();                       // E0 accepts
        start = 1'b0;
        din = 4'b0110;                // must have no effect
        n_checks++;
        if ({busy, sft_clr, sft_en} !== 3'b110) begin
            n_fail++;
            $display("FAIL basic_clr: busy/clr/en=%b required 110", {busy, sft_clr, sft_en});
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if ({busy, sft_clr, sft_en, sft_d} !== {3'b101, w[W-1-i]}) begin
                n_fail++;
                $display("FAIL basic_shift bit %0d: busy/clr/en/d=%b required %b", i,
                         {busy, sft_clr, sft_en, sft_d}, {3'b101, w[W-1-i]});
            end
        end
        step();                       // E5 -> CHECK
        n_checks++;
        if ({busy, sft_clr, sft_en, sft_d, done} !== 5'b10000) begin
            n_fail++;
            $display("FAIL basic_check: busy/clr/en/d/done=%b required 10000",
                     {busy, sft_clr, sft_en, sft_d, done});
        end
        step();                       // E6 -> done
        wait_done(0, "basic");
        step();
        n_checks++;
        if ({done, busy, dout} !== {2'b00, w}) begin
            n_fail++;
            $display("FAIL basic_after: done/busy/dout=%b required %b", {done, busy, dout},
                     {2'b00, w});
        end
    endtask

    task automatic test_stuck();
        logic [W-1:0] w;
        w = 4'b0101;
        stuck_mask = 4'b0001;
        din = w;
        start = 1'b1;
        push_exp(w);
        step();
        start = 1'b0;
        wait_done(20, "stuck");
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({dout, err} !== {4'b0100, last_err}) begin
                n_fail++;
                $display("FAIL stuck_hold cycle %0d: dout=%b err=%b required %b %b", i,
                         dout, err, 4'b0100, last_err);
            end
        end
        stuck_mask = '0;
        din = 4'b0110;
        start = 1'b1;
        push_exp(4'b0110);
        step();
        start = 1'b0;
        wait_done(20, "stuck_recover");
    endtask

    task automatic test_ignore();
        din = 4'b1111;
        start = 1'b1;
        push_exp(4'b1111);
        step();                       // E0
        start = 1'b0;
        step();                       // E1 -> SHIFT
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({sft_en, sft_d} !== 2'b11) begin
                n_fail++;
                $display("FAIL ignore_shift bit %0d: en/d=%b required 11", i, {sft_en, sft_d});
            end
            start = (i == 0 || i == 2);   // high across E2 and E4
            din = 4'b0000;
            step();
        end
        start = 1'b0;
        wait_done(5, "ignore");
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if ({done, busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL ignore_queued cycle %0d: done/busy=%b required 00", i,
                         {done, busy});
            end
        end
    endtask

    task automatic test_reset_mid();
        din = 4'b1111;
        start = 1'b1;
        push_exp(4'b1111);
        step();                       // E0
        start = 1'b0;
        step();                       // E1
        step();                       // E2
        step();                       // E3: two bits shifted
        n_checks++;
        if ({sft_en, sft_d} !== 2'b11) begin
            n_fail++;
            $display("FAIL midreset_pre: en/d=%b required 11", {sft_en, sft_d});
        end
        #2 res = 1'b0;
        #1;
        void'(exp_dout_q.pop_back());
        void'(exp_err_q.pop_back());
        n_checks++;
        if ({busy, sft_en, sft_d, done, dout} !== '0) begin
            n_fail++;
            $display("FAIL midreset_async: busy/en/d/done/dout=%b required 0",
                     {busy, sft_en, sft_d, done, dout});
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if ({busy, done} !== 2'b00) begin
                n_fail++;
                $display("FAIL midreset_held cycle %0d: busy/done=%b required 00", i,
                         {busy, done});
            end
        end
        #3 res = 1'b1;
        step();
        din = 4'b1001;
        start = 1'b1;
        push_exp(4'b1001);
        step();
        start = 1'b0;
        wait_done(20, "midreset_recover");
    endtask

    task automatic test_back_to_back();
        int last;
        int cyc;
        int ndone;
        logic [W-1:0] e_d;
        logic         e_e;
        last = -1;
        cyc = 0;
        ndone = 0;
        for (int i = 0; i < 3; i++) push_exp(4'b0011);
        din = 4'b0011;
        start = 1'b1;
        while (ndone < 3 && cyc < 60) begin
            step();
            cyc++;
            if (done) begin
                e_d = exp_dout_q.pop_front();
                e_e = exp_err_q.pop_front();
                n_checks++;
                if ({dout, err} !== {e_d, e_e}) begin
                    n_fail++;
                    $display("FAIL b2b_result %0d: dout=%b err=%b required %b %b", ndone,
                             dout, err, e_d, e_e);
                end
                if (last >= 0) begin
                    n_checks++;
                    if (cyc - last != 7) begin
                        n_fail++;
                        $display("FAIL b2b_period %0d: period=%0d required 7", ndone,
                                 cyc - last);
                    end
                end
                last = cyc;
                ndone++;
            end
        end
        start = 1'b0;
        n_checks++;
        if (ndone != 3) begin
            n_fail++;
            $display("FAIL b2b_count: dones=%0d required 3", ndone);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({done, busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL b2b_stop cycle %0d: done/busy=%b required 00", i, {done, busy});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stuck();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
